// File: rtl/kv_req_queue_if.sv
// DB-side channel of kv_req_queue: request handshake towards the lookup engine
// and the reply strobe coming back from it.
interface kv_req_queue_if #(
    parameter int KEY_SIZE = 96
);
    logic                db_req_valid;
    logic                db_req_ready;
    logic [KEY_SIZE-1:0] db_req_key;
    logic [3:0]          db_req_flag;
    logic                db_rep_valid;
    logic [3:0]          db_rep_flag;

    modport master (
        output db_req_valid,
        output db_req_key,
        output db_req_flag,
        input  db_req_ready,
        input  db_rep_valid,
        input  db_rep_flag
    );

    modport slave (
        input  db_req_valid,
        input  db_req_key,
        input  db_req_flag,
        output db_req_ready,
        output db_rep_valid,
        output db_rep_flag
    );
endinterface

// File: rtl/kv_req_queue.sv
// Buffers parser DB-request pulses in a FIFO, issues them with an outstanding limit,
// and forwards DB replies. Define KVQ_DEDUP_EN to suppress repeats of the newest queued entry.
module kv_req_queue #(
    parameter int KEY_SIZE        = 96,
    parameter int DEPTH_LOG2      = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk156,
    input  logic                eth_rst_n,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [3:0]          in_flag,
    input  logic                in_valid,
    output logic                out_valid,
    output logic [3:0]          out_flag,
    kv_req_queue_if.master      db,
    output logic [DEPTH_LOG2:0] occupancy,
    output logic [3:0]          outstanding,
    output logic [15:0]         drop_cnt,
    output logic                err_unexp_rep
`ifdef KVQ_DEDUP_EN
    ,
    output logic [15:0]         dedup_cnt
`endif
);

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam int         PW      = DEPTH_LOG2 + 1;
    localparam int         EW      = KEY_SIZE + 4;
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    logic [EW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] count_r;
    logic [3:0]    outstanding_r;
    logic [15:0]   drop_cnt_r;
    logic          err_r;
    logic          out_valid_r;
    logic [3:0]    out_flag_r;

    logic          empty_s;
    logic          full_s;
    logic          req_valid_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          dup_s;
    logic [EW-1:0] head_s;
    logic [EW-1:0] in_entry_s;
    logic [PW-1:0] count_nxt_s;
    logic [3:0]    outstanding_nxt_s;
    logic          err_nxt_s;

    assign in_entry_s  = {in_key, in_flag};
    assign head_s      = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
    assign empty_s     = (wr_ptr_r == rd_ptr_r);
    // Same slot index with differing wrap bit means the writer is a full lap ahead.
    assign full_s      = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                         (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
    assign req_valid_s = !empty_s && (outstanding_r < MAX_OUT);
    assign pop_s       = req_valid_s && db.db_req_ready;

`ifdef KVQ_DEDUP_EN
    logic [PW-1:0] tail_ptr_s;
    logic [15:0]   dedup_cnt_r;

    // The newest accepted entry is always the tail while the FIFO is non-empty.
    assign tail_ptr_s = wr_ptr_r - PW'(1);
    assign dup_s      = in_valid && !empty_s &&
                        (mem_r[tail_ptr_s[DEPTH_LOG2-1:0]] == in_entry_s);
    assign dedup_cnt  = dedup_cnt_r;

    // Count of suppressed duplicate requests.
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            dedup_cnt_r <= 16'd0;
        end else if (dup_s) begin
            dedup_cnt_r <= sat_inc16(dedup_cnt_r);
        end
    end
`else
    assign dup_s = 1'b0;
`endif

    // Admission: a full FIFO still takes a push when the head leaves this cycle.
    always_comb begin
        push_s = 1'b0;
        drop_s = 1'b0;
        if (in_valid && !dup_s) begin
            if (!full_s || pop_s) begin
                push_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Next entry count from this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + PW'(1);
            2'b01:   count_nxt_s = count_r - PW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Outstanding tracking; a reply with nothing in flight is flagged, never underflows.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        err_nxt_s         = err_r;
        if (db.db_rep_valid && (outstanding_r == 4'd0)) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end
        if (pop_s && !db.db_rep_valid) begin
            outstanding_nxt_s = outstanding_r + 4'd1;
        end else if (!pop_s && db.db_rep_valid && (outstanding_r != 4'd0)) begin
            outstanding_nxt_s = outstanding_r - 4'd1;
        end else begin
            outstanding_nxt_s = outstanding_r;
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk156) begin
        if (push_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= in_entry_s;
        end
    end

    // Pointers, counters, status and the registered reply path.
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            outstanding_r <= 4'd0;
            drop_cnt_r    <= 16'd0;
            err_r         <= 1'b0;
            out_valid_r   <= 1'b0;
            out_flag_r    <= 4'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (drop_s) begin
                drop_cnt_r <= sat_inc16(drop_cnt_r);
            end
            count_r       <= count_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            err_r         <= err_nxt_s;
            out_valid_r   <= db.db_rep_valid;
            out_flag_r    <= db.db_rep_valid ? db.db_rep_flag : 4'd0;
        end
    end

    // Key/flag are gated so the bus reads zero whenever nothing is offered.
    assign db.db_req_valid = req_valid_s;
    assign db.db_req_key   = req_valid_s ? head_s[EW-1:4] : '0;
    assign db.db_req_flag  = req_valid_s ? head_s[3:0] : 4'd0;

    assign out_valid     = out_valid_r;
    assign out_flag      = out_flag_r;
    assign occupancy     = count_r;
    assign outstanding   = outstanding_r;
    assign drop_cnt      = drop_cnt_r;
    assign err_unexp_rep = err_r;

endmodule

// File: tb/tb_kv_req_queue.sv
// Scoreboard bench for kv_req_queue: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_kv_req_queue;

    localparam int KS    = 96;
    localparam int DEPTH = 8;
    localparam int MAXO  = 4;

    logic          clk156 = 1'b0;
    logic          eth_rst_n;
    logic [KS-1:0] in_key;
    logic [3:0]    in_flag;
    logic          in_valid;
    logic          out_valid;
    logic [3:0]    out_flag;
    logic [3:0]    occupancy;
    logic [3:0]    outstanding;
    logic [15:0]   drop_cnt;
    logic          err_unexp_rep;
`ifdef KVQ_DEDUP_EN
    logic [15:0]   dedup_cnt;
`endif

    kv_req_queue_if #(.KEY_SIZE(KS)) dbif ();

    kv_req_queue #(.KEY_SIZE(KS), .DEPTH_LOG2(3), .MAX_OUTSTANDING(MAXO)) dut (
        .clk156        (clk156),
        .eth_rst_n     (eth_rst_n),
        .in_key        (in_key),
        .in_flag       (in_flag),
        .in_valid      (in_valid),
        .out_valid     (out_valid),
        .out_flag      (out_flag),
        .db            (dbif),
        .occupancy     (occupancy),
        .outstanding   (outstanding),
        .drop_cnt      (drop_cnt),
        .err_unexp_rep (err_unexp_rep)
`ifdef KVQ_DEDUP_EN
        ,
        .dedup_cnt     (dedup_cnt)
`endif
    );

    always #5 clk156 = ~clk156;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue of pending requests plus plain counters.
    logic [99:0] mq[$];
    logic [3:0]  exp_rep[$];
    int          m_out   = 0;
    int          m_drop  = 0;
    int          m_dedup = 0;
    bit          m_err   = 0;

    // Monitor: compare outputs with the model, then advance the model with the inputs
    // that the next rising edge will sample.
    always @(negedge clk156) begin
        bit m_valid;
        bit m_pop;
        bit dup;
        bit acc;
        if (!eth_rst_n) begin
            mq.delete();
            exp_rep.delete();
            m_out = 0; m_drop = 0; m_dedup = 0; m_err = 0;
        end
        m_valid = (mq.size() > 0) && (m_out < MAXO);
        check("db_req_valid", dbif.db_req_valid, m_valid);
        if (m_valid) begin
            check("db_req_key", dbif.db_req_key, mq[0][99:4]);
            check("db_req_flag", dbif.db_req_flag, mq[0][3:0]);
        end
        check("occupancy", occupancy, mq.size());
        check("outstanding", outstanding, m_out);
        check("drop_cnt", drop_cnt, m_drop);
        check("err_unexp_rep", err_unexp_rep, m_err);
`ifdef KVQ_DEDUP_EN
        check("dedup_cnt", dedup_cnt, m_dedup);
`endif
        if (exp_rep.size() > 0) begin
            check("out_valid", out_valid, 1'b1);
            check("out_flag", out_flag, exp_rep.pop_front());
        end else begin
            check("out_valid idle", out_valid, 1'b0);
            check("out_flag idle", out_flag, 4'd0);
        end

        if (eth_rst_n) begin
            m_pop = m_valid && dbif.db_req_ready;
            dup   = 1'b0;
`ifdef KVQ_DEDUP_EN
            dup = in_valid && (mq.size() > 0) && (mq[$] == {in_key, in_flag});
`endif
            acc = in_valid && !dup && ((mq.size() < DEPTH) || m_pop);
            if (in_valid && dup) begin
                if (m_dedup < 65535) m_dedup++;
            end else if (in_valid && !acc) begin
                if (m_drop < 65535) m_drop++;
            end
            if (dbif.db_rep_valid && m_out == 0) m_err = 1;
            if (m_pop && !dbif.db_rep_valid) m_out++;
            else if (!m_pop && dbif.db_rep_valid && m_out > 0) m_out--;
            if (m_pop) void'(mq.pop_front());
            if (acc) mq.push_back({in_key, in_flag});
            if (dbif.db_rep_valid) exp_rep.push_back(dbif.db_rep_flag);
        end
    end

    task automatic drive(input logic v, input logic [KS-1:0] k, input logic [3:0] f,
                         input logic rdy, input logic rv, input logic [3:0] rf);
        @(posedge clk156);
        #1;
        in_valid          = v;
        in_key            = k;
        in_flag           = f;
        dbif.db_req_ready = rdy;
        dbif.db_rep_valid = rv;
        dbif.db_rep_flag  = rf;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, 4'd0, rdy, 1'b0, 4'd0);
    endtask

    // Reset in the middle of a request burst; outputs must clear at once.
    task automatic do_reset();
        @(posedge clk156);
        #1;
        eth_rst_n = 1'b0;
        in_valid  = 1'b1;
        in_key    = 96'hDEAD_0000_0000_0000_0000_0001;
        in_flag   = 4'h6;
        @(negedge clk156);
        check("rst out_valid", out_valid, 1'b0);
        check("rst db_req_valid", dbif.db_req_valid, 1'b0);
        check("rst db_req_key", dbif.db_req_key, '0);
        check("rst occupancy", occupancy, 4'd0);
        check("rst outstanding", outstanding, 4'd0);
        check("rst drop_cnt", drop_cnt, 16'd0);
        check("rst err", err_unexp_rep, 1'b0);
        @(posedge clk156);
        #1;
        eth_rst_n = 1'b1;
        in_valid  = 1'b0;
        idle(1'b0);
        @(negedge clk156);
        check("post-rst occupancy", occupancy, 4'd0);
    endtask

    initial begin
        eth_rst_n         = 1'b0;
        in_valid          = 1'b0;
        in_key            = '0;
        in_flag           = 4'd0;
        dbif.db_req_ready = 1'b0;
        dbif.db_rep_valid = 1'b0;
        dbif.db_rep_flag  = 4'd0;
        repeat (3) @(posedge clk156);
        #1;
        eth_rst_n = 1'b1;
        @(negedge clk156);
        check("reset occupancy", occupancy, 4'd0);
        check("reset drop_cnt", drop_cnt, 16'd0);
        check("reset db_req_valid", dbif.db_req_valid, 1'b0);

        // Single request and its reply
        drive(1'b1, 96'hC0A80001_C0A80002_3039_0000, 4'b0011, 1'b1, 1'b0, 4'd0);
        idle(1'b1);
        @(negedge clk156);
        check("t1 db_req_valid", dbif.db_req_valid, 1'b1);
        check("t1 db_req_key", dbif.db_req_key, 96'hC0A80001_C0A80002_3039_0000);
        check("t1 db_req_flag", dbif.db_req_flag, 4'b0011);
        check("t1 outstanding before", outstanding, 4'd0);
        idle(1'b1);
        @(negedge clk156);
        check("t1 outstanding", outstanding, 4'd1);
        drive(1'b0, '0, 4'd0, 1'b1, 1'b1, 4'b0100);
        idle(1'b1);
        @(negedge clk156);
        check("t1 out_valid", out_valid, 1'b1);
        check("t1 out_flag", out_flag, 4'b0100);
        check("t1 outstanding after", outstanding, 4'd0);

        // Unexpected reply
        drive(1'b0, '0, 4'd0, 1'b0, 1'b1, 4'h9);
        idle(1'b0);
        @(negedge clk156);
        check("unexp out_valid", out_valid, 1'b1);
        check("unexp out_flag", out_flag, 4'h9);
        check("unexp err", err_unexp_rep, 1'b1);
        check("unexp outstanding", outstanding, 4'd0);

        // Overflow with the DB stalled
        for (int i = 0; i < 10; i++)
            drive(1'b1, 96'h100 + 96'(i), 4'(i), 1'b0, 1'b0, 4'd0);
        idle(1'b0);
        @(negedge clk156);
        check("ovf occupancy", occupancy, 4'd8);
        check("ovf drop_cnt", drop_cnt, 16'd2);
        check("ovf head key", dbif.db_req_key, 96'h100);

        // Full FIFO: push and pop in the same cycle
        drive(1'b1, 96'h1FF, 4'h5, 1'b1, 1'b0, 4'd0);
        idle(1'b0);
        @(negedge clk156);
        check("fullpp occupancy", occupancy, 4'd8);
        check("fullpp drop_cnt", drop_cnt, 16'd2);
        check("fullpp outstanding", outstanding, 4'd1);
        check("fullpp head key", dbif.db_req_key, 96'h101);
        do_reset();

        // Outstanding limit
        for (int i = 0; i < 6; i++)
            drive(1'b1, 96'h200 + 96'(i), 4'(i), 1'b1, 1'b0, 4'd0);
        repeat (4) idle(1'b1);
        @(negedge clk156);
        check("lim outstanding", outstanding, 4'd4);
        check("lim db_req_valid", dbif.db_req_valid, 1'b0);
        check("lim occupancy", occupancy, 4'd2);
        drive(1'b0, '0, 4'd0, 1'b1, 1'b1, 4'h7);
        idle(1'b1);
        @(negedge clk156);
        check("lim reissue valid", dbif.db_req_valid, 1'b1);
        check("lim reissue key", dbif.db_req_key, 96'h204);
        check("lim out_flag", out_flag, 4'h7);
        idle(1'b1);
        @(negedge clk156);
        check("lim outstanding again", outstanding, 4'd4);
        check("lim occupancy after", occupancy, 4'd1);
        for (int i = 0; i < 2; i++)
            drive(1'b1, 96'h300 + 96'(i), 4'(i), 1'b0, 1'b0, 4'd0);
        idle(1'b0);
        @(negedge clk156);
        check("3 queued", occupancy, 4'd3);
        do_reset();

        // Same key/flag twice while the first is still queued
        drive(1'b1, 96'hABC, 4'hA, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 96'hABC, 4'hA, 1'b0, 1'b0, 4'd0);
        idle(1'b0);
        @(negedge clk156);
        check("dup drop_cnt", drop_cnt, 16'd0);
`ifdef KVQ_DEDUP_EN
        check("dup occupancy", occupancy, 4'd1);
        check("dup dedup_cnt", dedup_cnt, 16'd1);
`else
        check("dup occupancy", occupancy, 4'd2);
`endif
        do_reset();

        // Random traffic, small key space so repeats and drops both occur
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk156);
            #1;
            eth_rst_n         = ($urandom_range(0, 599) != 0);
            in_valid          = ($urandom_range(0, 99) < 55);
            in_key            = 96'hFEED0000_00000000_00000000 | 96'($urandom_range(0, 3));
            in_flag           = 4'($urandom_range(0, 1));
            dbif.db_req_ready = ($urandom_range(0, 99) < 60);
            dbif.db_rep_valid = ($urandom_range(0, 99) < 30);
            dbif.db_rep_flag  = 4'($urandom_range(0, 15));
        end
        @(posedge clk156);
        #1;
        eth_rst_n = 1'b1;
        repeat (3) idle(1'b0);
        @(negedge clk156);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
